// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO responder: register offsets, FSM encoding and STATUS bit layout.
package mmio_pkg;

    localparam logic [3:0] OFF_STATUS   = 4'd0;
    localparam logic [3:0] OFF_CYCLE    = 4'd1;
    localparam logic [3:0] OFF_HALT     = 4'd2;
    localparam logic [3:0] OFF_WAITCFG  = 4'd3;
    localparam logic [3:0] OFF_SCRATCH0 = 4'd4;
    localparam logic [3:0] OFF_SCRATCH7 = 4'd11;

    localparam int STATUS_ONE_BIT  = 0;
    localparam int STATUS_HALT_BIT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic logic is_ro(input logic [3:0] off);
        return (off == OFF_STATUS) || (off == OFF_CYCLE) || (off == OFF_WAITCFG);
    endfunction

    function automatic logic is_scratch(input logic [3:0] off);
        return (off >= OFF_SCRATCH0) && (off <= OFF_SCRATCH7);
    endfunction

endpackage

// File: rtl/mmio_regfile.sv
// Register storage for the MMIO window: scratch array, sticky halt and read mux.
// Define MMIO_CYCLE_CNT_EN to add the free-running cycle counter at offset 1.
module mmio_regfile
    import mmio_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [3:0]        off,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data,
    output logic              halt
);

    logic [DATA_W-1:0] scratch_r [8];
    logic              halt_r;
    logic [2:0]        idx_s;

    assign idx_s = 3'(off - OFF_SCRATCH0);
    assign halt  = halt_r;

    // Write port: HALT sets the sticky flag, scratch offsets store data; everything else is ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            halt_r <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                scratch_r[i] <= '0;
            end
        end else if (wr_en) begin
            if (off == OFF_HALT) begin
                halt_r <= 1'b1;
            end
            if (is_scratch(off)) begin
                scratch_r[idx_s] <= wr_data;
            end
        end
    end

`ifdef MMIO_CYCLE_CNT_EN
    logic [15:0] cycle_r;

    // Free-running cycle counter, frozen once the CPU has halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_r <= 16'd0;
        end else if (!halt_r) begin
            cycle_r <= cycle_r + 16'd1;
        end
    end
`endif

    // Read mux by offset; reserved offsets read zero.
    always_comb begin
        rd_data = '0;
        case (off)
            OFF_STATUS: begin
                rd_data[STATUS_HALT_BIT] = halt_r;
                rd_data[STATUS_ONE_BIT]  = 1'b1;
            end
`ifdef MMIO_CYCLE_CNT_EN
            OFF_CYCLE:   rd_data = DATA_W'(cycle_r);
`else
            OFF_CYCLE:   rd_data = '0;
`endif
            OFF_HALT:    rd_data[0] = halt_r;
            OFF_WAITCFG: rd_data = DATA_W'(WAIT_CYCLES);
            default: begin
                if (is_scratch(off)) begin
                    rd_data = scratch_r[idx_s];
                end else begin
                    rd_data = '0;
                end
            end
        endcase
    end

endmodule

// File: rtl/mmio_responder.sv
// CPU data-port responder: window decode, wait-state FSM and registered bus response.
// Optional cycle counter at offset 1 is enabled with MMIO_CYCLE_CNT_EN.
module mmio_responder
    import mmio_pkg::*;
#(
    parameter int                DATA_W      = 16,
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'hFF00,
    parameter int                WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bus_req,
    input  logic              bus_we,
    input  logic [ADDR_W-1:0] bus_addr,
    input  logic [DATA_W-1:0] bus_wdata,
    output logic              bus_ack,
    output logic              bus_err,
    output logic [DATA_W-1:0] bus_rdata,
    output logic              halt
);

    state_t            state_r;
    logic [3:0]        cnt_r;
    logic              cap_we_r;
    logic [ADDR_W-1:0] cap_addr_r;
    logic [DATA_W-1:0] cap_wdata_r;

    logic              in_win_s;
    logic [3:0]        off_s;
    logic              wr_en_s;
    logic              err_s;
    logic [DATA_W-1:0] rd_data_s;

    // Decode of the captured request; only the RESP cycle commits anything.
    always_comb begin
        off_s    = cap_addr_r[3:0];
        in_win_s = (cap_addr_r[ADDR_W-1:4] == BASE_ADDR[ADDR_W-1:4]);
        wr_en_s  = (state_r == RESP) && cap_we_r && in_win_s;
        err_s    = !in_win_s || (cap_we_r && is_ro(off_s));
    end

    mmio_regfile #(
        .DATA_W      (DATA_W),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_regfile (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en_s),
        .off     (off_s),
        .wr_data (cap_wdata_r),
        .rd_data (rd_data_s),
        .halt    (halt)
    );

    // Request FSM. The ack cycle itself never captures, so a req still high afterwards is a new request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= IDLE;
            cnt_r       <= 4'd0;
            cap_we_r    <= 1'b0;
            cap_addr_r  <= '0;
            cap_wdata_r <= '0;
            bus_ack     <= 1'b0;
            bus_err     <= 1'b0;
            bus_rdata   <= '0;
        end else begin
            bus_ack   <= 1'b0;
            bus_err   <= 1'b0;
            bus_rdata <= '0;
            case (state_r)
                IDLE: begin
                    if (bus_req && !bus_ack) begin
                        cap_we_r    <= bus_we;
                        cap_addr_r  <= bus_addr;
                        cap_wdata_r <= bus_wdata;
                        cnt_r       <= 4'(WAIT_CYCLES);
                        state_r     <= (WAIT_CYCLES == 0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    cnt_r <= cnt_r - 4'd1;
                    if (cnt_r <= 4'd1) begin
                        state_r <= RESP;
                    end
                end
                RESP: begin
                    bus_ack   <= 1'b1;
                    bus_err   <= err_s;
                    bus_rdata <= (in_win_s && !cap_we_r) ? rd_data_s : '0;
                    state_r   <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: scoreboard of expected responses popped on each ack.
module tb_mmio_responder;

    localparam int WAIT_CYCLES = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_req;
    logic        bus_we;
    logic [15:0] bus_addr;
    logic [15:0] bus_wdata;
    logic        bus_ack;
    logic        bus_err;
    logic [15:0] bus_rdata;
    logic        halt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct packed {
        logic        err;
        logic [15:0] rdata;
        logic        chk_rd;
    } exp_t;

    exp_t sb[$];

    mmio_responder #(
        .DATA_W      (16),
        .ADDR_W      (16),
        .BASE_ADDR   (16'hFF00),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_ack   (bus_ack),
        .bus_err   (bus_err),
        .bus_rdata (bus_rdata),
        .halt      (halt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One bus transaction: push expectation, drive, wait (bounded) for ack, pop and compare.
    task automatic xfer(input string tag, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic exp_err, input logic [15:0] exp_rd,
                        input logic chk_rd, input logic drop,
                        output logic [15:0] rd, output int acyc);
        exp_t e;
        int   lat;
        logic got;
        sb.push_back('{err: exp_err, rdata: exp_rd, chk_rd: chk_rd});
        @(negedge clk);
        bus_req   = 1'b1;
        bus_we    = we;
        bus_addr  = addr;
        bus_wdata = wdata;
        @(posedge clk); #1;
        if (drop) bus_req = 1'b0;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (bus_ack) got = 1'b1;
        end
        bus_req = 1'b0;
        e = sb.pop_front();
        check_eq({tag, "_ack"}, 32'(got), 32'd1);
        check_eq({tag, "_lat"}, 32'(lat), 32'(WAIT_CYCLES + 1));
        check_eq({tag, "_err"}, 32'(bus_err), 32'(e.err));
        if (e.chk_rd) check_eq({tag, "_rdata"}, 32'(bus_rdata), 32'(e.rdata));
        rd   = bus_rdata;
        acyc = cyc;
        @(posedge clk); #1;
        check_eq({tag, "_pulse"}, 32'(bus_ack), 32'd0);
    endtask

    initial begin
        logic [15:0] r1, r2, d;
        int          c1, c2;

        // Reset held during an active HALT write request.
        rst       = 1'b1;
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 16'hFF02;
        bus_wdata = 16'h0001;
        repeat (5) @(posedge clk);
        #1;
        check_eq("rst_ack", 32'(bus_ack), 32'd0);
        check_eq("rst_rdata", 32'(bus_rdata), 32'd0);
        check_eq("rst_halt", 32'(halt), 32'd0);
        @(negedge clk);
        bus_req = 1'b0;
        rst     = 1'b0;

        xfer("status0", 1'b0, 16'hFF00, 16'h0, 1'b0, 16'h0001, 1'b1, 1'b0, r1, c1);
        xfer("wr_beef", 1'b1, 16'hFF04, 16'hBEEF, 1'b0, 16'h0000, 1'b1, 1'b0, r1, c1);
        xfer("rd_beef", 1'b0, 16'hFF04, 16'h0, 1'b0, 16'hBEEF, 1'b1, 1'b0, r1, c1);
        xfer("wr_s6", 1'b1, 16'hFF0A, 16'h1357, 1'b0, 16'h0000, 1'b1, 1'b0, r1, c1);
        xfer("rd_s6", 1'b0, 16'hFF0A, 16'h0, 1'b0, 16'h1357, 1'b1, 1'b0, r1, c1);
        xfer("rd_s0b", 1'b0, 16'hFF04, 16'h0, 1'b0, 16'hBEEF, 1'b1, 1'b0, r1, c1);
        xfer("oow_rd", 1'b0, 16'h1234, 16'h0, 1'b1, 16'h0000, 1'b1, 1'b0, r1, c1);
        xfer("oow_wr", 1'b1, 16'hFE04, 16'hDEAD, 1'b1, 16'h0000, 1'b1, 1'b0, r1, c1);
        xfer("rd_s0c", 1'b0, 16'hFF04, 16'h0, 1'b0, 16'hBEEF, 1'b1, 1'b0, r1, c1);
        xfer("waitcfg", 1'b0, 16'hFF03, 16'h0, 1'b0, 16'(WAIT_CYCLES), 1'b1, 1'b0, r1, c1);
        xfer("wr_wcfg", 1'b1, 16'hFF03, 16'h0009, 1'b1, 16'h0000, 1'b1, 1'b0, r1, c1);
        xfer("wr_stat", 1'b1, 16'hFF00, 16'hFFFF, 1'b1, 16'h0000, 1'b1, 1'b0, r1, c1);
        xfer("rsv_wr", 1'b1, 16'hFF0D, 16'h4444, 1'b0, 16'h0000, 1'b1, 1'b0, r1, c1);
        xfer("rsv_rd", 1'b0, 16'hFF0D, 16'h0, 1'b0, 16'h0000, 1'b1, 1'b0, r1, c1);
        xfer("halt_rd0", 1'b0, 16'hFF02, 16'h0, 1'b0, 16'h0000, 1'b1, 1'b0, r1, c1);

        // Cycle counter: read, attempt RO write, read again.
        xfer("cnt_rd1", 1'b0, 16'hFF01, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, r1, c1);
        xfer("cnt_wr", 1'b1, 16'hFF01, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b0, r2, c2);
        repeat (5) @(posedge clk);
        xfer("cnt_rd2", 1'b0, 16'hFF01, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, r2, c2);
`ifdef MMIO_CYCLE_CNT_EN
        d = r2 - r1;
        check_eq("cnt_delta", 32'(d), 32'(16'(c2 - c1)));
`else
        check_eq("cnt_zero1", 32'(r1), 32'd0);
        check_eq("cnt_zero2", 32'(r2), 32'd0);
`endif

        // Request dropped one cycle after capture still completes and commits.
        xfer("drop_wr", 1'b1, 16'hFF0B, 16'h00A5, 1'b0, 16'h0000, 1'b1, 1'b1, r1, c1);
        xfer("drop_rd", 1'b0, 16'hFF0B, 16'h0, 1'b0, 16'h00A5, 1'b1, 1'b0, r1, c1);

        // Halt: sticky, visible in STATUS, freezes the counter.
        check_eq("halt_pre", 32'(halt), 32'd0);
        xfer("halt_wr", 1'b1, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b0, r1, c1);
        check_eq("halt_set", 32'(halt), 32'd1);
        xfer("status1", 1'b0, 16'hFF00, 16'h0, 1'b0, 16'h0003, 1'b1, 1'b0, r1, c1);
        xfer("halt_rd1", 1'b0, 16'hFF02, 16'h0, 1'b0, 16'h0001, 1'b1, 1'b0, r1, c1);
        xfer("halt_wr2", 1'b1, 16'hFF02, 16'h1234, 1'b0, 16'h0000, 1'b1, 1'b0, r1, c1);
        xfer("wr_s1", 1'b1, 16'hFF05, 16'h7777, 1'b0, 16'h0000, 1'b1, 1'b0, r1, c1);
        check_eq("halt_keep", 32'(halt), 32'd1);
        xfer("cnt_h1", 1'b0, 16'hFF01, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, r1, c1);
        repeat (7) @(posedge clk);
        xfer("cnt_h2", 1'b0, 16'hFF01, 16'h0, 1'b0, 16'h0000, 1'b0, 1'b0, r2, c2);
        check_eq("cnt_frozen", 32'(r2), 32'(r1));

        // Reset mid-transaction: no ack, nothing committed, halt cleared.
        @(negedge clk);
        bus_req   = 1'b1;
        bus_we    = 1'b1;
        bus_addr  = 16'hFF06;
        bus_wdata = 16'hCAFE;
        @(posedge clk); #1;
        rst     = 1'b1;
        bus_req = 1'b0;
        d       = 16'h0;
        repeat (4) begin
            @(posedge clk); #1;
            if (bus_ack) d = 16'h1;
        end
        check_eq("rstmid_noack", 32'(d), 32'd0);
        check_eq("rstmid_halt", 32'(halt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        xfer("rstmid_rd", 1'b0, 16'hFF06, 16'h0, 1'b0, 16'h0000, 1'b1, 1'b0, r1, c1);
        xfer("rstmid_st", 1'b0, 16'hFF00, 16'h0, 1'b0, 16'h0001, 1'b1, 1'b0, r1, c1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
